// File: rtl/dma_channel_engine_if.sv
// Bus bundle of the single-channel DMA engine: register-write stream, memory port, IO port, status.
// The engine connects through the master modport; the programmer/memory/IO side uses slave.
interface dma_channel_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_ack;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata;
    logic              io_rd;
    logic              io_wr;
    logic              io_ack;
    logic              busy;
    logic              tc;
    logic [3:0]        status;

    modport master (
        input  reg_wr, reg_addr, reg_data, mem_rdata, mem_ack, io_rdata, io_ack,
        output mem_addr, mem_wdata, mem_rd, mem_wr, io_wdata, io_rd, io_wr, busy, tc, status
    );

    modport slave (
        output reg_wr, reg_addr, reg_data, mem_rdata, mem_ack, io_rdata, io_ack,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, io_wdata, io_rd, io_wr, busy, tc, status
    );
endinterface

// File: rtl/dma_channel_engine.sv
// 8237-style single-channel DMA engine: register decode plus RD/WR/NEXT word-transfer FSM.
// Optional DMA_AUTOINIT_EN: with mode bit4 set, terminal count reloads the channel and keeps it unmasked.
//
// state | meaning
// IDLE  | waiting for an unmasked request write
// RD    | read strobe out (mem or IO), waiting for ack
// WR    | write strobe out (mem or IO), waiting for ack
// NEXT  | decrement count, step addresses
// DONE  | one-cycle terminal-count pulse
module dma_channel_engine #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int ADDR_STEP = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    dma_channel_engine_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_NEXT, S_DONE} state_t;
    typedef enum logic [1:0] {X_M2M, X_IO2M, X_M2IO} xfer_t;

    localparam logic [ADDR_W-1:0] A_SRC  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(10);
    localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(11);
    localparam logic [ADDR_W-1:0] A_REQ  = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] A_DST  = ADDR_W'(13);

    state_t            state_q, state_d;
    xfer_t             xfer_q, xfer_d;
    logic [ADDR_W-1:0] src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [DATA_W-1:0] word_count_q, word_count_d, cmd_q, cmd_d, mode_q, mode_d;
    logic              mask_q, mask_d;
    logic [ADDR_W-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [DATA_W-1:0] cur_cnt_q, cur_cnt_d, hold_q, hold_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, io_rd_q, io_rd_d, io_wr_q, io_wr_d;
    logic              cfg_err_q, cfg_err_d, abort_q, abort_d, tc_seen_q, tc_seen_d;
    logic              start_ok, ack_seen;
    logic              unused_cfg;

    assign ack_seen   = ((mem_rd_q | mem_wr_q) & bus.mem_ack) | ((io_rd_q | io_wr_q) & bus.io_ack);
    assign unused_cfg = ^{cmd_q[DATA_W-1:1], mode_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            xfer_q       <= X_M2M;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            word_count_q <= '0;
            cmd_q        <= '0;
            mode_q       <= '0;
            mask_q       <= 1'b1;
            cur_src_q    <= '0;
            cur_dst_q    <= '0;
            cur_cnt_q    <= '0;
            hold_q       <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            io_rd_q      <= 1'b0;
            io_wr_q      <= 1'b0;
            cfg_err_q    <= 1'b0;
            abort_q      <= 1'b0;
            tc_seen_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            xfer_q       <= xfer_d;
            src_base_q   <= src_base_d;
            dst_base_q   <= dst_base_d;
            word_count_q <= word_count_d;
            cmd_q        <= cmd_d;
            mode_q       <= mode_d;
            mask_q       <= mask_d;
            cur_src_q    <= cur_src_d;
            cur_dst_q    <= cur_dst_d;
            cur_cnt_q    <= cur_cnt_d;
            hold_q       <= hold_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            io_rd_q      <= io_rd_d;
            io_wr_q      <= io_wr_d;
            cfg_err_q    <= cfg_err_d;
            abort_q      <= abort_d;
            tc_seen_q    <= tc_seen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        xfer_d       = xfer_q;
        src_base_d   = src_base_q;
        dst_base_d   = dst_base_q;
        word_count_d = word_count_q;
        cmd_d        = cmd_q;
        mode_d       = mode_q;
        mask_d       = mask_q;
        cur_src_d    = cur_src_q;
        cur_dst_d    = cur_dst_q;
        cur_cnt_d    = cur_cnt_q;
        hold_d       = hold_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        io_rd_d      = io_rd_q;
        io_wr_d      = io_wr_q;
        cfg_err_d    = cfg_err_q;
        abort_d      = abort_q;
        tc_seen_d    = tc_seen_q;
        start_ok     = 1'b0;

        // Base registers always take writes; the running transfer works from the cur_* copies.
        if (bus.reg_wr) begin
            case (bus.reg_addr)
                A_SRC:   src_base_d   = ADDR_W'(bus.reg_data);
                A_CNT:   word_count_d = bus.reg_data;
                A_CMD:   cmd_d        = bus.reg_data;
                A_MODE:  mode_d       = bus.reg_data;
                A_MASK:  mask_d       = bus.reg_data[0];
                A_DST:   dst_base_d   = ADDR_W'(bus.reg_data);
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (bus.reg_wr && bus.reg_addr == A_REQ && !mask_q) begin
                    start_ok = 1'b1;
                    if (cmd_q[0])                 xfer_d = X_M2M;
                    else if (mode_q[3:2] == 2'b10) xfer_d = X_IO2M;
                    else if (mode_q[3:2] == 2'b01) xfer_d = X_M2IO;
                    else begin
                        start_ok  = 1'b0;
                        cfg_err_d = 1'b1;
                    end
                    if (start_ok) begin
                        cur_src_d = src_base_q;
                        cur_dst_d = dst_base_q;
                        cur_cnt_d = word_count_q;
                        cfg_err_d = 1'b0;
                        abort_d   = 1'b0;
                        if (word_count_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RD;
                            if (xfer_d == X_IO2M) io_rd_d = 1'b1;
                            else                  mem_rd_d = 1'b1;
                        end
                    end
                end
            end
            S_RD: begin
                if (ack_seen) begin
                    hold_d   = io_rd_q ? bus.io_rdata : bus.mem_rdata;
                    mem_rd_d = 1'b0;
                    io_rd_d  = 1'b0;
                    // A mask write during the transfer is the abort request.
                    if (mask_q) begin
                        state_d = S_IDLE;
                        abort_d = 1'b1;
                    end else begin
                        state_d = S_WR;
                        if (xfer_q == X_M2IO) io_wr_d = 1'b1;
                        else                  mem_wr_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (ack_seen) begin
                    mem_wr_d = 1'b0;
                    io_wr_d  = 1'b0;
                    if (mask_q) begin
                        state_d = S_IDLE;
                        abort_d = 1'b1;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                cur_cnt_d = cur_cnt_q - DATA_W'(1);
                cur_src_d = cur_src_q + ADDR_W'(ADDR_STEP);
                cur_dst_d = cur_dst_q + ADDR_W'(ADDR_STEP);
                if (mask_q) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                end else if (cur_cnt_q == DATA_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                    if (xfer_q == X_IO2M) io_rd_d = 1'b1;
                    else                  mem_rd_d = 1'b1;
                end
            end
            S_DONE: begin
                tc_seen_d = 1'b1;
                state_d   = S_IDLE;
`ifdef DMA_AUTOINIT_EN
                if (mode_q[4]) begin
                    cur_src_d = src_base_q;
                    cur_dst_d = dst_base_q;
                    cur_cnt_d = word_count_q;
                end else begin
                    mask_d = 1'b1;
                end
`else
                mask_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr = '0;
        if (state_q == S_RD && xfer_q != X_IO2M)      bus.mem_addr = cur_src_q;
        else if (state_q == S_WR && xfer_q == X_M2M)  bus.mem_addr = cur_dst_q;
        else if (state_q == S_WR && xfer_q == X_IO2M) bus.mem_addr = cur_src_q;
    end

    assign bus.mem_wdata = hold_q;
    assign bus.io_wdata  = hold_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.io_rd     = io_rd_q;
    assign bus.io_wr     = io_wr_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.tc        = (state_q == S_DONE);
    assign bus.status    = {abort_q, cfg_err_q, mask_q, tc_seen_q};
endmodule

// File: tb/tb_dma_channel_engine.sv
// Directed bench for dma_channel_engine: IO2MEM, MEM2MEM, MEM2IO wrap, errors, abort, reset, autoinit.
module tb_dma_channel_engine;
    localparam int K_MRD = 0, K_MWR = 1, K_IRD = 2, K_IWR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   tc_cnt = 0;
    int   strobe_cyc = 0;
    int   tc0, st0;

    dma_channel_engine_if #(.DATA_W(16), .ADDR_W(16)) bus_if ();

    dma_channel_engine #(.DATA_W(16), .ADDR_W(16), .ADDR_STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.tc) tc_cnt++;
        if (bus_if.mem_rd | bus_if.mem_wr | bus_if.io_rd | bus_if.io_wr) strobe_cyc++;
    end

    function automatic logic strobe(input int kind);
        case (kind)
            K_MRD:   return bus_if.mem_rd;
            K_MWR:   return bus_if.mem_wr;
            K_IRD:   return bus_if.io_rd;
            default: return bus_if.io_wr;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
        bus_if.reg_wr   = 1'b1;
        bus_if.reg_addr = a;
        bus_if.reg_data = d;
        @(negedge clk);
        bus_if.reg_wr   = 1'b0;
    endtask

    task automatic wait_strobe(input int kind, input string tag);
        int i;
        for (i = 0; i < 30; i++) begin
            if (strobe(kind)) break;
            @(negedge clk);
        end
        if (i == 30) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_ack(input int kind, input logic [15:0] rdata);
        if (kind == K_MRD || kind == K_MWR) begin
            bus_if.mem_ack = 1'b1; bus_if.mem_rdata = rdata;
        end else begin
            bus_if.io_ack = 1'b1; bus_if.io_rdata = rdata;
        end
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        bus_if.io_ack  = 1'b0;
    endtask

    task automatic service(input int kind, input logic [15:0] exp_addr, input logic [15:0] rdata,
                           input logic [15:0] exp_wdata, input int lat, input string tag);
        wait_strobe(kind, tag);
        if (kind == K_MRD || kind == K_MWR) chk({tag, "_addr"}, bus_if.mem_addr, exp_addr);
        if (kind == K_MWR) chk({tag, "_wdata"}, bus_if.mem_wdata, exp_wdata);
        if (kind == K_IWR) chk({tag, "_wdata"}, bus_if.io_wdata, exp_wdata);
        repeat (lat) @(negedge clk);
        if (lat > 0) chk({tag, "_held"}, strobe(kind), 1'b1);
        do_ack(kind, rdata);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 30; i++) begin
            if (!bus_if.busy) break;
            @(negedge clk);
        end
        if (i == 30) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        bus_if.reg_wr = 1'b0; bus_if.reg_addr = '0; bus_if.reg_data = '0;
        bus_if.mem_rdata = '0; bus_if.mem_ack = 1'b0;
        bus_if.io_rdata = '0; bus_if.io_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_status", bus_if.status, 4'b0010);
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_strobes", {bus_if.mem_rd, bus_if.mem_wr, bus_if.io_rd, bus_if.io_wr, bus_if.tc}, 5'b0);
        chk("rst_mem_addr", bus_if.mem_addr, 16'h0000);
        chk("rst_wdata", {bus_if.mem_wdata, bus_if.io_wdata}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // IO -> memory, three words, growing ack latency on the IO side
        tc0 = tc_cnt;
        wr_reg(16'd0, 16'h0100); wr_reg(16'd1, 16'd3); wr_reg(16'd10, 16'h0008);
        wr_reg(16'd11, 16'h0000); wr_reg(16'd12, 16'h0000);
        chk("io2mem_busy", bus_if.busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            service(K_IRD, 16'h0, 16'hA000 + 16'(k), 16'h0, k, "io2mem_rd");
            service(K_MWR, 16'h0100 + 16'(4 * k), 16'h0, 16'hA000 + 16'(k), 0, "io2mem_wr");
        end
        wait_idle("io2mem");
        chk("io2mem_tc", tc_cnt - tc0, 1);
        chk("io2mem_status", bus_if.status, 4'b0011);

        // memory -> memory
        tc0 = tc_cnt;
        wr_reg(16'd0, 16'h0010); wr_reg(16'd13, 16'h0200); wr_reg(16'd1, 16'd2);
        wr_reg(16'd7, 16'h0001); wr_reg(16'd11, 16'h0000); wr_reg(16'd12, 16'h0000);
        service(K_MRD, 16'h0010, 16'h1111, 16'h0, 0, "m2m_rd0");
        service(K_MWR, 16'h0200, 16'h0, 16'h1111, 1, "m2m_wr0");
        service(K_MRD, 16'h0014, 16'h2222, 16'h0, 0, "m2m_rd1");
        chk("m2m_tc_early", tc_cnt - tc0, 0);
        service(K_MWR, 16'h0204, 16'h0, 16'h2222, 0, "m2m_wr1");
        wait_idle("m2m");
        chk("m2m_tc", tc_cnt - tc0, 1);

        // memory -> IO with address wrap
        tc0 = tc_cnt;
        wr_reg(16'd0, 16'hFFFC); wr_reg(16'd1, 16'd2); wr_reg(16'd10, 16'h0004);
        wr_reg(16'd7, 16'h0000); wr_reg(16'd11, 16'h0000); wr_reg(16'd12, 16'h0000);
        service(K_MRD, 16'hFFFC, 16'h3333, 16'h0, 0, "m2io_rd0");
        service(K_IWR, 16'h0, 16'h0, 16'h3333, 0, "m2io_wr0");
        service(K_MRD, 16'h0000, 16'h4444, 16'h0, 2, "m2io_rd1");
        service(K_IWR, 16'h0, 16'h0, 16'h4444, 0, "m2io_wr1");
        wait_idle("m2io");
        chk("m2io_tc", tc_cnt - tc0, 1);

        // illegal mode with command bit0 clear
        wr_reg(16'd10, 16'h0000); wr_reg(16'd11, 16'h0000); wr_reg(16'd12, 16'h0000);
        chk("cfg_busy", bus_if.busy, 1'b0);
        chk("cfg_status", bus_if.status, 4'b0101);

        // request while masked is ignored
        wr_reg(16'd10, 16'h0008); wr_reg(16'd11, 16'h0001); wr_reg(16'd12, 16'h0000);
        chk("masked_busy", bus_if.busy, 1'b0);
        chk("masked_status", bus_if.status, 4'b0111);

        // zero word count: straight to terminal count
        tc0 = tc_cnt; st0 = strobe_cyc;
        wr_reg(16'd1, 16'd0); wr_reg(16'd11, 16'h0000); wr_reg(16'd12, 16'h0000);
        chk("zero_tc_now", bus_if.tc, 1'b1);
        repeat (2) @(negedge clk);
        chk("zero_tc", tc_cnt - tc0, 1);
        chk("zero_strobes", strobe_cyc - st0, 0);
        chk("zero_status", bus_if.status, 4'b0011);

        // abort mid-transfer with a slow memory read
        tc0 = tc_cnt;
        wr_reg(16'd0, 16'h0400); wr_reg(16'd1, 16'd4); wr_reg(16'd10, 16'h0004);
        wr_reg(16'd7, 16'h0000); wr_reg(16'd11, 16'h0000); wr_reg(16'd12, 16'h0000);
        chk("abort_status_start", bus_if.status, 4'b0001);
        service(K_MRD, 16'h0400, 16'h5A5A, 16'h0, 0, "abort_rd0");
        service(K_IWR, 16'h0, 16'h0, 16'h5A5A, 0, "abort_wr0");
        wait_strobe(K_MRD, "abort_rd1");
        chk("abort_rd1_addr", bus_if.mem_addr, 16'h0404);
        wr_reg(16'd11, 16'h0001);
        repeat (4) @(negedge clk);
        chk("abort_rd_held", bus_if.mem_rd, 1'b1);
        do_ack(K_MRD, 16'h6B6B);
        chk("abort_idle", bus_if.busy, 1'b0);
        chk("abort_strobes", {bus_if.mem_rd, bus_if.mem_wr, bus_if.io_rd, bus_if.io_wr}, 4'b0);
        repeat (3) @(negedge clk);
        chk("abort_status", bus_if.status, 4'b1011);
        chk("abort_no_tc", tc_cnt - tc0, 0);

        // asynchronous reset during a write cycle
        wr_reg(16'd0, 16'h0500); wr_reg(16'd1, 16'd2); wr_reg(16'd10, 16'h0008);
        wr_reg(16'd11, 16'h0000); wr_reg(16'd12, 16'h0000);
        service(K_IRD, 16'h0, 16'h7777, 16'h0, 0, "rst_io_rd");
        wait_strobe(K_MWR, "rst_mem_wr");
        chk("rst_wr_addr", bus_if.mem_addr, 16'h0500);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {bus_if.mem_rd, bus_if.mem_wr, bus_if.io_rd, bus_if.io_wr}, 4'b0);
        chk("rst_mid_busy", bus_if.busy, 1'b0);
        chk("rst_mid_status", bus_if.status, 4'b0010);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef DMA_AUTOINIT_EN
        tc0 = tc_cnt;
        wr_reg(16'd0, 16'h0600); wr_reg(16'd1, 16'd1); wr_reg(16'd10, 16'h0018);
        wr_reg(16'd11, 16'h0000); wr_reg(16'd12, 16'h0000);
        service(K_IRD, 16'h0, 16'h8888, 16'h0, 0, "ai_rd0");
        service(K_MWR, 16'h0600, 16'h0, 16'h8888, 0, "ai_wr0");
        wait_idle("ai0");
        chk("ai_tc0", tc_cnt - tc0, 1);
        chk("ai_status", bus_if.status, 4'b0001);
        wr_reg(16'd12, 16'h0000);
        service(K_IRD, 16'h0, 16'h9999, 16'h0, 0, "ai_rd1");
        service(K_MWR, 16'h0600, 16'h0, 16'h9999, 0, "ai_wr1");
        wait_idle("ai1");
        chk("ai_tc1", tc_cnt - tc0, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
